multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel memory-mapped timer/counter bridge peripheral for the P7 MIPS system. It replaces the single-channel TC with NUM_CH independent down-counters. Each channel adds auto-reload, a power-of-two prescaler and a sticky write-1-to-clear interrupt flag. All channels share one bus port and one combined IRQ line to the CP0 interrupt input.

## Interface
- NUM_CH, 2: number of channels, 1..4; channel index = Addr[5:4].
- WIDTH, 32: COUNT/PRESET width; registers read zero-extended to 32 bits.
- PS_W, 16: prescaler counter width; the PRESCALE field must be < PS_W.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all registers and states.
- Addr  in  32  byte address; Addr[5:4] selects the channel, Addr[3:2] selects the register; other bits ignored.
- WE  in  1  write strobe for the addressed register.
- Din  in  32  write data.
- Dout  out  32  combinational read of the addressed register.
- IRQ  out  1  OR over channels of (CTRL.IM & STATUS.PEND).

## Operation
- Registers per channel, by Addr[3:2]:
  - 0 CTRL: [0] EN, [2:1] MODE, [3] IM, [7:4] PRESCALE; all other bits write-ignored and read 0.
  - 1 PRESET.
  - 2 COUNT, writable.
  - 3 STATUS: [0] PEND (read; write 1 clears, write 0 no effect); [2:1] state (read-only).
- MODE values: 00 one-shot, clears EN on expiry. 01 auto-reload, keeps EN. 10/11 behave as 01.
- Channels with index >= NUM_CH read 0; writes to them are dropped.
- A bus write to channel k blocks all FSM/prescaler activity of channel k in that cycle. Other channels advance normally.
- Per-channel FSM, evaluated only when channel k is not being written:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; prescaler counter <= 0; go to CNT.
  - CNT: if !EN, go to IDLE (COUNT holds). Else, on a tick: if COUNT > 1 then COUNT - 1; else COUNT <= 0, PEND <= 1, go to INT.
  - INT: if MODE == 00, EN <= 0. Go to IDLE.
- Tick: the prescaler counter increments each CNT cycle. A tick fires when it equals 2^PRESCALE - 1, and the counter then wraps to 0. PRESCALE = 0 gives a tick every cycle.
- PEND is sticky. It is never cleared by the FSM, only by a W1C write or by reset.
- PRESET = 0 behaves as PRESET = 1.
- Arithmetic is unsigned WIDTH-bit. COUNT never wraps below 0.

## Timing
- Reset: all registers 0, all FSMs IDLE, prescaler counters 0, IRQ 0, Dout reflects registers immediately.
- Write CTRL.EN=1 at edge E0, PRESCALE=0, PRESET=N>=1:
  - E1: state becomes LOAD.
  - E2: COUNT=N.
  - E(N+2): COUNT=0, PEND=1, and IRQ rises if IM=1.
- With prescale P: expiry at E(2 + N*2^P).
- Auto-reload period is N*2^P + 3 cycles (INT, IDLE, LOAD overhead).
- Clearing EN during CNT: IDLE at the next unblocked edge, and COUNT is frozen.
- A W1C of PEND on the same edge that another channel sets its PEND: both take effect independently.
- Reset mid-count aborts immediately. No IRQ follows.

## Structure
- Shared header timer_defs.vh holds:
  - state encodings IDLE/LOAD/CNT/INT (2'b00..2'b11);
  - register offsets;
  - CTRL bit positions;
  - MODE codes.
- Sub-module timer_channel holds one channel's registers, FSM, prescaler and PEND. It takes a channel write enable, register select, Din and reset, and produces its read mux output and its irq term.
- multi_timer does address decode, generates NUM_CH timer_channel instances, and provides the Dout mux and the IRQ OR.

## Test plan
- Reset, then read all registers of ch0/ch1: every value is 0 and IRQ=0. Writing CTRL=0xFFFF_FFFF reads back 0x0000_00FF.
- ch0: PRESET=3, CTRL=0x9 (EN, IM, one-shot) -> IRQ rises 5 edges after the CTRL write, COUNT=0, EN reads 0, and IRQ stays high until STATUS is written with 1, after which IRQ=0.
- ch1: PRESET=2, CTRL=0xB (auto-reload, IM) -> PEND set every 5 cycles. W1C between expiries re-arms the flag. IRQ falls only after W1C.
- ch0: PRESCALE=2, PRESET=4, one-shot -> expiry 18 edges after the CTRL write. Clearing EN mid-count freezes COUNT and returns the state to IDLE.
- Both channels running. A write to ch1 PRESET stalls ch1 for one cycle only; ch0 expiry timing is unchanged. IRQ is high if either enabled channel is pending with IM set.
- Access to channel 3 with NUM_CH=2: the read returns 0 and the write has no effect on any channel.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared definitions for the multi-channel timer.
//   - per-channel FSM state encoding
//   - register offsets (Addr[3:2])
//   - CTRL field positions and MODE codes
//   - prescaler terminal-count helper
package multi_timer_pkg;

    // FSM states; the encoding is visible to software in STATUS[2:1].
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StCnt  = 2'b10,
        StInt  = 2'b11
    } tmr_state_e;

    // Register offsets within a channel, selected by Addr[3:2].
    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegPreset = 2'd1;
    localparam logic [1:0] RegCount  = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    // CTRL field positions.
    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlImBit   = 3;
    localparam int unsigned CtrlPsLsb   = 4;
    localparam int unsigned CtrlWidth   = 8;

    // MODE codes. Anything other than one-shot keeps EN (auto-reload).
    localparam logic [1:0] ModeOneShot = 2'b00;
    localparam logic [1:0] ModeReload  = 2'b01;

    // Prescaler value at which a tick fires: 2^prescale - 1.
    function automatic logic [31:0] ps_limit(input logic [3:0] prescale);
        return (32'd1 << prescale) - 32'd1;
    endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// multi_timer_channel: one timer channel (registers, FSM, prescaler, sticky PEND).
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   wr_en_i    bus write aimed at this channel; stalls the FSM/prescaler this cycle
//   reg_sel_i  register select (Addr[3:2]) for both read and write
//   din_i      write data
//   rdata_o    combinational read data of the selected register, zero-extended
//   irq_o      interrupt term: CTRL.IM & STATUS.PEND
module multi_timer_channel
    import multi_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PS_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic [1:0]  reg_sel_i,
    input  logic [31:0] din_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    tmr_state_e       state_q;
    logic             en_q;
    logic [1:0]       mode_q;
    logic             im_q;
    logic [3:0]       prescale_q;
    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] count_q;
    logic             pend_q;
    logic [PS_W-1:0]  ps_cnt_q;

    logic [PS_W-1:0]  ps_max;
    logic             tick;

    assign ps_max = PS_W'(ps_limit(prescale_q));
    assign tick   = (ps_cnt_q == ps_max);

    // A bus write to this channel takes priority and freezes all counting activity
    // for that cycle. PRESET = 0 needs no special case: the first tick finds
    // COUNT <= 1 and expires, exactly as PRESET = 1 does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            prescale_q <= 4'd0;
            preset_q   <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            ps_cnt_q   <= '0;
        end else if (wr_en_i) begin
            unique case (reg_sel_i)
                RegCtrl: begin
                    en_q       <= din_i[CtrlEnBit];
                    mode_q     <= din_i[CtrlModeLsb +: 2];
                    im_q       <= din_i[CtrlImBit];
                    prescale_q <= din_i[CtrlPsLsb +: 4];
                end
                RegPreset: preset_q <= din_i[WIDTH-1:0];
                RegCount:  count_q  <= din_i[WIDTH-1:0];
                RegStatus: begin
                    if (din_i[0]) begin
                        pend_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en_q) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q  <= preset_q;
                    ps_cnt_q <= '0;
                    state_q  <= StCnt;
                end
                StCnt: begin
                    if (!en_q) begin
                        // COUNT and the prescaler hold their values.
                        state_q <= StIdle;
                    end else if (tick) begin
                        ps_cnt_q <= '0;
                        if (count_q > WIDTH'(1)) begin
                            count_q <= count_q - WIDTH'(1);
                        end else begin
                            count_q <= '0;
                            pend_q  <= 1'b1;
                            state_q <= StInt;
                        end
                    end else begin
                        ps_cnt_q <= ps_cnt_q + PS_W'(1);
                    end
                end
                StInt: begin
                    if (mode_q == ModeOneShot) begin
                        en_q <= 1'b0;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (reg_sel_i)
            RegCtrl:   rdata_o[CtrlWidth-1:0] = {prescale_q, im_q, mode_q, en_q};
            RegPreset: rdata_o[WIDTH-1:0]     = preset_q;
            RegCount:  rdata_o[WIDTH-1:0]     = count_q;
            RegStatus: rdata_o[2:0]           = {state_q, pend_q};
            default: ;
        endcase
    end

    assign irq_o = im_q & pend_q;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent down-counting timers behind one bus port.
//
// Ports:
//   clk     clock, all state updates on posedge
//   reset   synchronous active-high reset
//   addr_i  byte address; [5:4] channel, [3:2] register, other bits ignored
//   we_i    write strobe for the addressed register
//   din_i   write data
//   dout_o  combinational read of the addressed register (0 for absent channels)
//   irq_o   OR over channels of CTRL.IM & STATUS.PEND
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned PS_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] din_i,
    output logic [31:0] dout_o,
    output logic        irq_o
);

    logic [1:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] ch_irq;
    logic              unused_addr;

    assign ch_sel      = addr_i[5:4];
    assign reg_sel     = addr_i[3:2];
    assign unused_addr = ^{addr_i[31:6], addr_i[1:0]};

    // Channels >= NUM_CH have no instance, so writes to them match nothing.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_timer_channel #(
            .WIDTH (WIDTH),
            .PS_W  (PS_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (we_i && (ch_sel == 2'(i))),
            .reg_sel_i (reg_sel),
            .din_i     (din_i),
            .rdata_o   (ch_rdata[i]),
            .irq_o     (ch_irq[i])
        );
    end

    always_comb begin
        dout_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 2'(i)) begin
                dout_o = ch_rdata[i];
            end
        end
    end

    assign irq_o = |ch_irq;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: scoreboard-driven bench for multi_timer (NUM_CH=2).
// Expected values are queued when stimulus is applied and popped at the compare.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    multi_timer #(
        .NUM_CH (2),
        .WIDTH  (32),
        .PS_W   (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr_i (addr),
        .we_i   (we),
        .din_i  (din),
        .dout_o (dout),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sb_push(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The write lands on the next posedge; returns 1ns after that edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic test_reset;
        logic [31:0] got;
        exp_t        e;
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 4; r++) begin
                sb_push($sformatf("reset_ch%0d_reg%0d", ch, r), 32'h0);
                rd(32'((ch << 4) | (r << 2)), got);
                e = sb_q.pop_front();
                checks++;
                if (got !== e.val) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
            end
        end
        sb_push("reset_irq", 32'h0);
        e = sb_q.pop_front();
        checks++;
        if ({31'b0, irq} !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
        wr(32'h00, 32'hFFFF_FFFF);
        sb_push("ctrl_mask_readback", 32'h0000_00FF);
        rd(32'h00, got);
        e = sb_q.pop_front();
        checks++;
        if (got !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        wr(32'h00, 32'h0);
    endtask

    task automatic test_oneshot;
        logic [31:0] got;
        exp_t        e;
        int          start;
        int          n;
        wr(32'h04, 32'd3);
        wr(32'h00, 32'h9);
        start = edge_cnt;
        sb_push("oneshot_irq_edges", 32'd5);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (32'(edge_cnt - start) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", e.name, edge_cnt - start, e.val);
        end
        sb_push("oneshot_count_zero", 32'h0);
        rd(32'h08, got);
        e = sb_q.pop_front();
        checks++;
        if (got !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        tick();
        sb_push("oneshot_en_cleared", 32'h8);
        sb_push("oneshot_status_pend", 32'h1);
        for (int i = 0; i < 2; i++) begin
            rd((i == 0) ? 32'h00 : 32'h0C, got);
            e = sb_q.pop_front();
            checks++;
            if (got !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        tick(4);
        sb_push("oneshot_irq_sticky", 32'h1);
        e = sb_q.pop_front();
        checks++;
        if ({31'b0, irq} !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
        wr(32'h0C, 32'h1);
        sb_push("oneshot_irq_after_w1c", 32'h0);
        e = sb_q.pop_front();
        checks++;
        if ({31'b0, irq} !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
    endtask

    task automatic test_reload;
        logic [31:0] got;
        exp_t        e;
        int          start;
        int          n;
        logic [31:0] exp_edges [3];
        wr(32'h14, 32'd2);
        wr(32'h10, 32'hB);
        start = edge_cnt;
        sb_push("reload_first_expiry", 32'd4);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (32'(edge_cnt - start) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", e.name, edge_cnt - start, e.val);
        end
        // Period between successive INT states without any bus write to ch1.
        start = edge_cnt;
        sb_push("reload_period", 32'd5);
        n = 0;
        do begin
            tick();
            n++;
            rd(32'h1C, got);
        end while (got[2:1] !== 2'b11 && n < 100);
        e = sb_q.pop_front();
        checks++;
        if (32'(edge_cnt - start) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", e.name, edge_cnt - start, e.val);
        end
        // W1C during INT stalls ch1 one cycle: next expiry 5 edges later.
        // A second W1C during LOAD gives 3 edges to the following expiry.
        exp_edges[0] = 32'd5;
        exp_edges[1] = 32'd3;
        for (int k = 0; k < 2; k++) begin
            wr(32'h1C, 32'h1);
            start = edge_cnt;
            sb_push($sformatf("reload_irq_low_after_w1c%0d", k), 32'h0);
            e = sb_q.pop_front();
            checks++;
            if ({31'b0, irq} !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
            end
            sb_push($sformatf("reload_rearm_edges%0d", k), exp_edges[k]);
            n = 0;
            while (irq !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            e = sb_q.pop_front();
            checks++;
            if (32'(edge_cnt - start) !== e.val) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d", e.name, edge_cnt - start, e.val);
            end
            if (k == 0) begin
                tick(2);
                sb_push("reload_irq_held", 32'h1);
                e = sb_q.pop_front();
                checks++;
                if ({31'b0, irq} !== e.val) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
                end
            end
        end
        wr(32'h10, 32'h0);
        tick(3);
        wr(32'h1C, 32'h1);
        sb_push("reload_stopped_status", 32'h0);
        rd(32'h1C, got);
        e = sb_q.pop_front();
        checks++;
        if (got !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
    endtask

    task automatic test_preset_zero;
        logic [31:0] got;
        exp_t        e;
        int          start;
        int          n;
        wr(32'h14, 32'd0);
        wr(32'h10, 32'h9);
        start = edge_cnt;
        sb_push("preset0_expiry", 32'd3);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (32'(edge_cnt - start) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", e.name, edge_cnt - start, e.val);
        end
        wr(32'h1C, 32'h1);
        tick(2);
        sb_push("preset0_ctrl", 32'h8);
        sb_push("preset0_status", 32'h0);
        for (int i = 0; i < 2; i++) begin
            rd((i == 0) ? 32'h10 : 32'h1C, got);
            e = sb_q.pop_front();
            checks++;
            if (got !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_prescale;
        logic [31:0] got;
        exp_t        e;
        int          start;
        int          n;
        wr(32'h04, 32'd4);
        wr(32'h00, 32'h29);
        start = edge_cnt;
        sb_push("prescale_expiry", 32'd18);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (32'(edge_cnt - start) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", e.name, edge_cnt - start, e.val);
        end
        tick();
        wr(32'h0C, 32'h1);
        // Restart, then clear EN at the 8th edge: COUNT is 3 at that point.
        wr(32'h00, 32'h29);
        tick(7);
        wr(32'h00, 32'h28);
        sb_push("freeze_state_cnt", 32'h4);
        sb_push("freeze_count", 32'd3);
        for (int i = 0; i < 2; i++) begin
            rd((i == 0) ? 32'h0C : 32'h08, got);
            e = sb_q.pop_front();
            checks++;
            if (got !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        tick();
        sb_push("freeze_state_idle", 32'h0);
        rd(32'h0C, got);
        e = sb_q.pop_front();
        checks++;
        if (got !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        tick(6);
        sb_push("freeze_count_held", 32'd3);
        rd(32'h08, got);
        e = sb_q.pop_front();
        checks++;
        if (got !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got;
        exp_t        e;
        int          start;
        int          n;
        wr(32'h04, 32'd6);
        wr(32'h14, 32'd3);
        wr(32'h00, 32'h9);
        start = edge_cnt;
        wr(32'h10, 32'h9);
        // Extra PRESET write stalls ch1 for one cycle: ch1 expiry moves from 6 to 7.
        wr(32'h14, 32'd3);
        sb_push("both_first_irq", 32'd7);
        sb_push("both_ch0_running", 32'h4);
        sb_push("both_ch1_pending", 32'h7);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (32'(edge_cnt - start) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", e.name, edge_cnt - start, e.val);
        end
        for (int i = 0; i < 2; i++) begin
            rd((i == 0) ? 32'h0C : 32'h1C, got);
            e = sb_q.pop_front();
            checks++;
            if (got !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        sb_push("both_ch0_expiry", 32'd8);
        n = 0;
        rd(32'h0C, got);
        while (got[0] !== 1'b1 && n < 100) begin
            tick();
            n++;
            rd(32'h0C, got);
        end
        e = sb_q.pop_front();
        checks++;
        if (32'(edge_cnt - start) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", e.name, edge_cnt - start, e.val);
        end
        wr(32'h1C, 32'h1);
        sb_push("both_irq_ch0_only", 32'h1);
        e = sb_q.pop_front();
        checks++;
        if ({31'b0, irq} !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
        wr(32'h0C, 32'h1);
        sb_push("both_irq_cleared", 32'h0);
        e = sb_q.pop_front();
        checks++;
        if ({31'b0, irq} !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
    endtask

    task automatic test_reset_midcount;
        logic [31:0] got;
        exp_t        e;
        int          n;
        wr(32'h04, 32'd5);
        wr(32'h00, 32'h9);
        tick(3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (irq !== 1'b0) n++;
        end
        sb_push("midreset_no_irq", 32'h0);
        e = sb_q.pop_front();
        checks++;
        if (32'(n) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0d irq cycles expected %0d", e.name, n, e.val);
        end
        for (int r = 0; r < 4; r++) begin
            sb_push($sformatf("midreset_ch0_reg%0d", r), 32'h0);
            rd(32'(r << 2), got);
            e = sb_q.pop_front();
            checks++;
            if (got !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] got;
        exp_t        e;
        logic [31:0] raddr [7];
        wr(32'h04, 32'h11);
        wr(32'h14, 32'h22);
        wr(32'h30, 32'hFF);
        wr(32'h34, 32'h55);
        wr(32'h38, 32'h7);
        tick(10);
        raddr = '{32'h30, 32'h34, 32'h2C, 32'h00, 32'h10, 32'h04, 32'h114};
        sb_push("ch3_ctrl_zero", 32'h0);
        sb_push("ch3_preset_zero", 32'h0);
        sb_push("ch2_status_zero", 32'h0);
        sb_push("unmapped_ch0_ctrl", 32'h0);
        sb_push("unmapped_ch1_ctrl", 32'h0);
        sb_push("unmapped_ch0_preset", 32'h11);
        sb_push("alias_ch1_preset", 32'h22);
        for (int i = 0; i < 7; i++) begin
            rd(raddr[i], got);
            e = sb_q.pop_front();
            checks++;
            if (got !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        sb_push("unmapped_irq", 32'h0);
        e = sb_q.pop_front();
        checks++;
        if ({31'b0, irq} !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_preset_zero();
        test_prescale();
        test_back_to_back();
        test_reset_midcount();
        test_unmapped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
